// File: rtl/unpack_ascan.sv
// Receive-side A-scan unpacker: byte-restores 32-bit link words and emits
// MSB-first packed 12-bit samples, stopping after MAX_SAMPLES per frame.
module unpack_ascan #(
  parameter int unsigned MAX_SAMPLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sync,
  input  logic [31:0] i_in_data,
  input  logic        i_in_vld,
  output logic        o_in_rdy,
  output logic [11:0] o_out_data,
  output logic        o_out_vld,
  input  logic        i_out_rdy,
  output logic [15:0] o_sample_cnt,
  output logic        o_done
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned SREG_W   = WORD_W + SAMPLE_W;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned SCNT_W   = 16;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t              state;
  logic [SREG_W-1:0]   sreg;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   word_v;
  logic [CNT_W-1:0]    top_idx;
  logic                running;
  logic                have_sample;
  logic                accept;
  logic                emit;

  // Undo the link's byte swap so the stream reads MSB-first.
  assign word_v = {i_in_data[7:0], i_in_data[15:8], i_in_data[23:16], i_in_data[31:24]};

  assign running     = (state == RUN);
  assign have_sample = (cnt >= CNT_W'(SAMPLE_W));
  assign top_idx     = cnt - CNT_W'(1);

  // Handshake outputs depend only on registered state.
  assign o_in_rdy   = !running || !have_sample;
  assign o_out_vld  = running && have_sample;
  assign o_out_data = o_out_vld ? sreg[top_idx -: SAMPLE_W] : '0;
  assign o_done     = (state == DRAIN);

  assign accept = running && !have_sample && i_in_vld;
  assign emit   = o_out_vld && i_out_rdy;

  // In DRAIN accept is gated off, so incoming words are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg         <= '0;
      cnt          <= '0;
      o_sample_cnt <= '0;
      state        <= RUN;
    end else if (i_sync) begin
      cnt          <= '0;
      o_sample_cnt <= '0;
      state        <= RUN;
    end else if (accept) begin
      sreg <= {sreg[SAMPLE_W-1:0], word_v};
      cnt  <= cnt + CNT_W'(WORD_W);
    end else if (emit) begin
      cnt          <= cnt - CNT_W'(SAMPLE_W);
      o_sample_cnt <= o_sample_cnt + SCNT_W'(1);
      if ((o_sample_cnt + SCNT_W'(1)) == SCNT_W'(MAX_SAMPLES)) begin
        state <= DRAIN;
      end
    end
  end

endmodule

// File: tb/tb_unpack_ascan.sv
// Directed bench for unpack_ascan: two instances (default frame length and
// a 5-sample frame) share the input stimulus.
module tb_unpack_ascan;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_sync;
  logic [31:0] i_in_data;
  logic        i_in_vld;
  logic        i_out_rdy;

  logic        a_in_rdy, a_out_vld, a_done;
  logic [11:0] a_out_data;
  logic [15:0] a_sample_cnt;
  logic        b_in_rdy, b_out_vld, b_done;
  logic [11:0] b_out_data;
  logic [15:0] b_sample_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wq[$];
  logic [11:0] got[$];

  always #5 clk = ~clk;

  unpack_ascan dut (
    .clk(clk), .rst(rst), .i_sync(i_sync),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(a_in_rdy),
    .o_out_data(a_out_data), .o_out_vld(a_out_vld), .i_out_rdy(i_out_rdy),
    .o_sample_cnt(a_sample_cnt), .o_done(a_done)
  );

  unpack_ascan #(.MAX_SAMPLES(5)) dut_b (
    .clk(clk), .rst(rst), .i_sync(i_sync),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(b_in_rdy),
    .o_out_data(b_out_data), .o_out_vld(b_out_vld), .i_out_rdy(i_out_rdy),
    .o_sample_cnt(b_sample_cnt), .o_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Streams wq into the selected instance, collecting samples into got.
  task automatic run(input int max_cycles, input int want, input bit rand_rdy,
                     input bit use_b, output int consumed);
    int wi = 0;
    logic rdy_o, vld_o;
    logic [11:0] dat_o;
    for (int c = 0; c < max_cycles && got.size() < want; c++) begin
      i_in_vld  = (wi < wq.size());
      i_in_data = i_in_vld ? wq[wi] : 32'h0;
      i_out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      rdy_o = use_b ? b_in_rdy   : a_in_rdy;
      vld_o = use_b ? b_out_vld  : a_out_vld;
      dat_o = use_b ? b_out_data : a_out_data;
      if (i_in_vld && rdy_o) wi++;
      if (vld_o && i_out_rdy) got.push_back(dat_o);
      @(posedge clk);
      #1;
    end
    i_in_vld  = 1'b0;
    i_out_rdy = 1'b0;
    consumed  = wi;
  endtask

  logic [11:0] basic_exp[5];
  logic [11:0] samples[$];
  logic [31:0] acc;
  int          nbits;
  int          consumed;
  int          errs;

  initial begin
    basic_exp[0] = 12'h123; basic_exp[1] = 12'h456; basic_exp[2] = 12'h789;
    basic_exp[3] = 12'hABC; basic_exp[4] = 12'hDEF;
    rst = 1'b1; i_sync = 1'b0; i_in_data = '0; i_in_vld = 1'b0; i_out_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    check("rst_in_rdy", 32'(a_in_rdy), 32'd1);
    check("rst_out_vld", 32'(a_out_vld), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_sample_cnt", 32'(a_sample_cnt), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);

    // Basic unpack
    pulse_sync();
    wq = '{32'h78563412, 32'hF0DEBC9A};
    got.delete();
    run(50, 5, 1'b0, 1'b0, consumed);
    check("basic_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) check($sformatf("basic_s%0d", i), 32'(got[i]), 32'(basic_exp[i]));
    check("basic_sample_cnt", 32'(a_sample_cnt), 32'd5);
    check("basic_resid_cnt", 32'(dut.cnt), 32'd4);
    check("basic_vld_after", 32'(a_out_vld), 32'd0);

    // Backpressure: first word in, consumer stalled for 5 cycles
    pulse_sync();
    i_in_vld = 1'b1; i_in_data = 32'h78563412; i_out_rdy = 1'b0;
    tick();
    i_in_data = 32'hF0DEBC9A;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_data%0d", i), 32'(a_out_data), 32'h123);
      check($sformatf("bp_in_rdy%0d", i), 32'(a_in_rdy), 32'd0);
      check($sformatf("bp_vld%0d", i), 32'(a_out_vld), 32'd1);
      tick();
    end
    wq = '{32'hF0DEBC9A};
    got.delete();
    run(50, 5, 1'b0, 1'b0, consumed);
    check("bp_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) check($sformatf("bp_s%0d", i), 32'(got[i]), 32'(basic_exp[i]));

    // Round trip: 1000 random samples packed MSB-first into 375 swapped words
    samples.delete();
    wq.delete();
    acc = '0; nbits = 0;
    for (int i = 0; i < 1000; i++) samples.push_back(12'($urandom_range(0, 4095)));
    for (int i = 0; i < 1000; i++) begin
      for (int b = 11; b >= 0; b--) begin
        acc = {acc[30:0], samples[i][b]};
        nbits++;
        if (nbits == 32) begin
          wq.push_back(bswap(acc));
          nbits = 0;
        end
      end
    end
    pulse_sync();
    got.delete();
    run(20000, 1000, 1'b1, 1'b0, consumed);
    check("rt_words", 32'(wq.size()), 32'd375);
    check("rt_n", 32'(got.size()), 32'd1000);
    errs = 0;
    for (int i = 0; i < got.size() && i < 1000; i++) if (got[i] !== samples[i]) errs++;
    check("rt_errs", 32'(errs), 32'd0);
    check("rt_sample_cnt", 32'(a_sample_cnt), 32'd1000);

    // Frame limit on the 5-sample instance
    pulse_sync();
    wq = '{32'h78563412, 32'hF0DEBC9A, 32'h11111111, 32'h22222222};
    got.delete();
    run(40, 10, 1'b0, 1'b1, consumed);
    check("lim_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) check($sformatf("lim_s%0d", i), 32'(got[i]), 32'(basic_exp[i]));
    check("lim_consumed", 32'(consumed), 32'd4);
    check("lim_done", 32'(b_done), 32'd1);
    check("lim_vld", 32'(b_out_vld), 32'd0);
    check("lim_in_rdy", 32'(b_in_rdy), 32'd1);
    check("lim_sample_cnt", 32'(b_sample_cnt), 32'd5);

    // Reset while draining with input pending
    i_in_vld = 1'b1; i_in_data = 32'hDEADBEEF; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstd_in_rdy", 32'(b_in_rdy), 32'd1);
    check("rstd_out_vld", 32'(b_out_vld), 32'd0);
    check("rstd_out_data", 32'(b_out_data), 32'd0);
    check("rstd_sample_cnt", 32'(b_sample_cnt), 32'd0);
    check("rstd_done", 32'(b_done), 32'd0);
    i_in_vld = 1'b0;

    // Sync concurrent with an emit handshake at cnt = 20
    pulse_sync();
    i_in_vld = 1'b1; i_in_data = 32'h78563412; i_out_rdy = 1'b0;
    tick();
    i_in_vld = 1'b0; i_out_rdy = 1'b1;
    tick();
    check("sync_pre_cnt", 32'(dut.cnt), 32'd20);
    check("sync_pre_data", 32'(a_out_data), 32'h456);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0; i_out_rdy = 1'b0;
    check("sync_cnt", 32'(dut.cnt), 32'd0);
    check("sync_sample_cnt", 32'(a_sample_cnt), 32'd0);
    check("sync_vld", 32'(a_out_vld), 32'd0);
    check("sync_in_rdy", 32'(a_in_rdy), 32'd1);
    wq = '{32'hEFCDAB89};
    got.delete();
    run(20, 2, 1'b0, 1'b0, consumed);
    check("sync_n", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("sync_s0", 32'(got[0]), 32'h89A);
      check("sync_s1", 32'(got[1]), 32'hBCD);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
